// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the 1101 detector: WIDTH-bit words in over valid/ready,
// one bit per clock out, with seamless back-to-back streaming and first/last bit markers.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             at_last;
  logic             accept;

  // Ready in the last-bit cycle lets the next word load with no bubble.
  always_comb begin
    at_last   = (state_q == StShift) && (cnt_q == LastCnt);
    din_ready = !rst && ((state_q == StIdle) || at_last);
    accept    = din_valid && din_ready;
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sh_d    = din;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (!at_last) begin
          sh_d  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
        end else if (accept) begin
          sh_d  = din;
          cnt_d = '0;
        end else begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ser_valid = (state_q == StShift);
    ser_out   = ser_valid ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
    ser_first = ser_valid && (cnt_q == '0);
    ser_last  = ser_valid && (cnt_q == LastCnt);
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: an MSB-first and an LSB-first instance share clk/rst.
module tb_seq_bit_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din, din_l;
  logic       din_valid, din_valid_l;
  logic       din_ready, ser_out, ser_valid, ser_first, ser_last;
  logic       din_ready_l, ser_out_l, ser_valid_l, ser_first_l, ser_last_l;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic val;
    logic first;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .ser_last  (ser_last)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .din       (din_l),
    .din_valid (din_valid_l),
    .din_ready (din_ready_l),
    .ser_out   (ser_out_l),
    .ser_valid (ser_valid_l),
    .ser_first (ser_first_l),
    .ser_last  (ser_last_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bit order is derived from the word and direction alone.
  function automatic void push_word(input logic [7:0] w, input bit msb);
    for (int i = 0; i < 8; i++) begin
      exp_t x;
      x.val   = msb ? w[7-i] : w[i];
      x.first = (i == 0);
      x.last  = (i == 7);
      exp_q.push_back(x);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; din = 8'hFF; din_valid = 1'b1; din_l = 8'hFF; din_valid_l = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({ser_valid, ser_out, ser_first, ser_last, din_ready} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold%0d v/o/f/l/rdy got %b required 00000", c,
                 {ser_valid, ser_out, ser_first, ser_last, din_ready});
      end
      checks++;
      if ({ser_valid_l, ser_out_l, din_ready_l} !== 3'b0) begin
        errors++;
        $display("FAIL reset_hold_lsb%0d v/o/rdy got %b required 000", c,
                 {ser_valid_l, ser_out_l, din_ready_l});
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; din_valid = 1'b0; din_valid_l = 1'b0;
    @(negedge clk);
    checks++;
    if ({din_ready, ser_valid, ser_out} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release rdy/v/o got %b required 100", {din_ready, ser_valid, ser_out});
    end
    checks++;
    if (din_ready_l !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_lsb rdy got %b required 1", din_ready_l);
    end
  endtask

  task automatic test_single_msb();
    @(posedge clk); #1;
    din = 8'hD0; din_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b required 1", din_ready);
    end
    push_word(8'hD0, 1'b1);
    @(posedge clk); #1;
    din_valid = 1'b0; din = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({ser_valid, ser_out, ser_first, ser_last, din_ready} !==
          {1'b1, e.val, e.first, e.last, (k == 7)}) begin
        errors++;
        $display("FAIL single_bit%0d v/o/f/l/rdy got %b required %b", k,
                 {ser_valid, ser_out, ser_first, ser_last, din_ready},
                 {1'b1, e.val, e.first, e.last, (k == 7)});
      end
    end
    @(negedge clk);
    checks++;
    if ({ser_valid, ser_out, din_ready} !== 3'b001) begin
      errors++;
      $display("FAIL single_after v/o/rdy got %b required 001", {ser_valid, ser_out, din_ready});
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    din = 8'hD5; din_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_initial got %b required 1", din_ready);
    end
    push_word(8'hD5, 1'b1);
    @(posedge clk); #1;
    din = 8'h3B;
    push_word(8'h3B, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({ser_valid, ser_out, ser_first, ser_last, din_ready} !==
          {1'b1, e.val, e.first, e.last, (k == 7 || k == 15)}) begin
        errors++;
        $display("FAIL b2b_bit%0d v/o/f/l/rdy got %b required %b", k,
                 {ser_valid, ser_out, ser_first, ser_last, din_ready},
                 {1'b1, e.val, e.first, e.last, (k == 7 || k == 15)});
      end
      if (k == 7) begin
        @(posedge clk); #1;
        din_valid = 1'b0; din = 8'hFF;
      end
    end
    @(negedge clk);
    checks++;
    if ({ser_valid, ser_out} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_after v/o got %b required 00", {ser_valid, ser_out});
    end
  endtask

  task automatic test_lsb_first();
    @(posedge clk); #1;
    din_l = 8'h0B; din_valid_l = 1'b1;
    push_word(8'h0B, 1'b0);
    @(posedge clk); #1;
    din_valid_l = 1'b0; din_l = 8'hA4;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({ser_valid_l, ser_out_l, ser_first_l, ser_last_l} !== {1'b1, e.val, e.first, e.last})
      begin
        errors++;
        $display("FAIL lsb_bit%0d v/o/f/l got %b required %b", k,
                 {ser_valid_l, ser_out_l, ser_first_l, ser_last_l},
                 {1'b1, e.val, e.first, e.last});
      end
    end
    @(negedge clk);
    checks++;
    if ({ser_valid_l, ser_out_l} !== 2'b00) begin
      errors++;
      $display("FAIL lsb_after v/o got %b required 00", {ser_valid_l, ser_out_l});
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    din = 8'hD5; din_valid = 1'b1;
    push_word(8'hD5, 1'b1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({ser_valid, ser_out, ser_first, ser_last} !== {1'b1, e.val, e.first, e.last}) begin
        errors++;
        $display("FAIL midrst_bit%0d v/o/f/l got %b required %b", k,
                 {ser_valid, ser_out, ser_first, ser_last}, {1'b1, e.val, e.first, e.last});
      end
    end
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({ser_valid, ser_out, ser_first, ser_last, din_ready} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_abort v/o/f/l/rdy got %b required 00000",
               {ser_valid, ser_out, ser_first, ser_last, din_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0; din = 8'hB0; din_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({din_ready, ser_valid} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_release rdy/v got %b required 10", {din_ready, ser_valid});
    end
    push_word(8'hB0, 1'b1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({ser_valid, ser_out, ser_first, ser_last} !== {1'b1, e.val, e.first, e.last}) begin
        errors++;
        $display("FAIL midrst_new_bit%0d v/o/f/l got %b required %b", k,
                 {ser_valid, ser_out, ser_first, ser_last}, {1'b1, e.val, e.first, e.last});
      end
    end
    @(negedge clk);
    checks++;
    if ({ser_valid, ser_out} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_after v/o got %b required 00", {ser_valid, ser_out});
    end
  endtask

  task automatic test_idle_gaps();
    @(posedge clk); #1;
    din = 8'hD0; din_valid = 1'b1;
    for (int w = 0; w < 2; w++) begin
      push_word(8'hD0, 1'b1);
      @(posedge clk); #1;
      din_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({ser_valid, ser_out, ser_first, ser_last} !== {1'b1, e.val, e.first, e.last}) begin
          errors++;
          $display("FAIL gap_word%0d_bit%0d v/o/f/l got %b required %b", w, k,
                   {ser_valid, ser_out, ser_first, ser_last}, {1'b1, e.val, e.first, e.last});
        end
        // Toggle din, and raise din_valid mid-word where it must be ignored.
        @(posedge clk); #1;
        din = 8'($urandom);
        din_valid = (k >= 1 && k <= 4);
        if (k < 7) begin
          @(negedge clk);
          e = exp_q.pop_front();
          checks++;
          if ({ser_valid, ser_out, ser_first, ser_last} !== {1'b1, e.val, e.first, e.last}) begin
            errors++;
            $display("FAIL gap_word%0d_bit%0d v/o/f/l got %b required %b", w, k + 1,
                     {ser_valid, ser_out, ser_first, ser_last}, {1'b1, e.val, e.first, e.last});
          end
          k++;
          if (k < 7) begin
            @(posedge clk); #1;
            din = 8'($urandom);
            din_valid = (k >= 1 && k <= 4);
          end
        end
      end
      din_valid = 1'b0;
      for (int g = 0; g < 5; g++) begin
        @(negedge clk);
        checks++;
        if ({ser_valid, ser_out} !== 2'b00) begin
          errors++;
          $display("FAIL gap_word%0d_idle%0d v/o got %b required 00", w, g,
                   {ser_valid, ser_out});
        end
        if (g == 4 && w == 0) begin
          din = 8'hD0; din_valid = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; din_l = '0; din_valid_l = 1'b0;
    test_reset();
    test_single_msb();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid();
    test_idle_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Parallel-to-serial front end for the 1101 sequence-detector path. It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clk on `ser_out`, which drives the detector's serial input `i` directly. Back-to-back words stream with no idle cycle, so the detector sees a continuous bit stream. The block also marks the first and last bit of each word for downstream bookkeeping.

## Interface

- `WIDTH`, 8: bits per word; legal range is 2 or more.
- `MSB_FIRST`, 1: 1 sends `din[WIDTH-1]` first; 0 sends `din[0]` first.
- `IDLE_BIT`, 0: value driven on `ser_out` whenever `ser_valid` is low.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `din` input WIDTH: word to serialize; sampled only on an accept.
- `din_valid` input 1: upstream has a word on `din`.
- `din_ready` output 1: block can accept a word this cycle.
- `ser_out` output 1: serial bit; connects to the detector input `i`.
- `ser_valid` output 1: `ser_out` carries a payload bit this cycle.
- `ser_first` output 1: high on bit 0 of a word.
- `ser_last` output 1: high on bit WIDTH-1 of a word.

## Operation

- **States:** IDLE and SHIFT.
- **Registers:**
  - shift register `sh` (WIDTH bits)
  - bit counter `cnt` ($clog2(WIDTH) bits)
  - state
- **Accept:** occurs when `din_valid && din_ready` at a rising edge.
- **din_ready:** combinational. It is `!rst && (state==IDLE || (state==SHIFT && cnt==WIDTH-1))`.
- **IDLE:**
  - On accept: `sh<=din`, `cnt<=0`, go to SHIFT.
  - Otherwise hold.
- **SHIFT, cnt < WIDTH-1:**
  - Shift by one toward the output end. With MSB_FIRST=1 this is a left shift; with 0 it is a right shift.
  - `cnt<=cnt+1`.
  - `din_valid` is ignored in this state.
- **SHIFT, cnt == WIDTH-1 (last bit):**
  - On accept: load `sh<=din`, `cnt<=0`, stay in SHIFT. This is the seamless back-to-back case.
  - Otherwise go to IDLE and set `cnt<=0`.
- **Output decode** (combinational from registers):
  - `ser_valid = (state==SHIFT)`.
  - `ser_out = ser_valid ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT`.
  - `ser_first = ser_valid && cnt==0`.
  - `ser_last = ser_valid && cnt==WIDTH-1`.
- **Source stability:** `din` may change freely when no accept occurs. The word is captured at the accept edge only.
- **Shifted-in fill:** 0. It is never visible, because `ser_valid` drops or a new word loads first.

## Timing

- **Reset values** (cycle after `rst` is sampled high, and held while `rst` is high):
  - state IDLE, `sh=0`, `cnt=0`
  - `ser_valid=0`, `ser_out=IDLE_BIT`, `ser_first=0`, `ser_last=0`
  - `din_ready=0` while `rst` is high; 1 in the first cycle after `rst` drops.
- **Latency:** for a word accepted at edge E, bit k appears on `ser_out` in the cycle following edge E+k, for k=0..WIDTH-1. This gives one cycle of latency to the first bit.
- **Throughput:** one bit per cycle. With `din_valid` held high, words stream with zero gap cycles.
- **Ready timing:** `din_ready` is high only in IDLE and in the last-bit cycle of SHIFT. In all other SHIFT cycles it is low.
- **Simultaneous last bit and accept:** the new word's bit 0 follows directly. `ser_first` is high in the cycle immediately after `ser_last`.
- **Reset mid-word:** the word is aborted with no residual bits. The cycle after the reset edge shows `ser_valid=0` and `ser_out=IDLE_BIT`. The partial word is never resumed.
- **Reset wins** over a simultaneous accept.
- **Gaps:** when `din_valid` is low in IDLE, `ser_out` holds `IDLE_BIT`. The detector therefore sees the idle value between words.

## Test plan

1. **Reset values:** assert `rst` for 2 cycles with `din_valid=1`, `din=8'hFF`. Required: `ser_valid=0`, `ser_out=0`, `din_ready=0` throughout, and no word is accepted. After release, `din_ready=1`.
2. **Single word, MSB first:** `din=8'hD0`, `din_valid` pulsed for one cycle. Required: `ser_out` = 1,1,0,1,0,0,0,0 over 8 consecutive cycles starting one cycle after the accept. `ser_first` is high in cycle 1 and `ser_last` in cycle 8, then `ser_valid=0`. A connected detector pulses `q` on the 4th bit.
3. **Back-to-back words:** `din_valid` held high, `8'hD5` then `8'h3B`. Required: 16 contiguous valid bits 1101_0101_0011_1011. `din_ready` is high only in the initial accept cycle and in both last-bit cycles, and `ser_valid` has no gap.
4. **LSB first:** `MSB_FIRST=0`, `din=8'h0B`. Required: `ser_out` = 1,1,0,1,0,0,0,0.
5. **Reset mid-word:** `din=8'hD5` accepted, then `rst` asserted after 3 bits have been sent. Required: the next cycle shows `ser_valid=0` and `ser_out=0`. After release, `din_ready=1`, and a new word `8'hB0` serializes from its bit 0 with no leftover bits.
6. **Idle gaps and source stability:** words `8'hD0` and `8'hD0` separated by 5 cycles of `din_valid=0`, with `din` toggled during SHIFT. Required: 5 `ser_valid=0` cycles at `ser_out=0` between the words, and both words emit exactly 1,1,0,1,0,0,0,0.
